// File: rtl/alu_seq_pkg.sv
// Shared constants and state encoding for the ALU operation sequencer.
package alu_seq_pkg;

  localparam int DATA_W = 32;

  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_SUB = 4'b0001;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    RESP   = 2'd2
  } seq_state_t;

endpackage

// File: rtl/alu_ovf_detect.sv
// Signed overflow flag for ADD/SUB from operand and result sign bits.
// Any opcode other than ADD or SUB never reports overflow.
module alu_ovf_detect
  import alu_seq_pkg::*;
(
  input  logic [3:0] opcode,
  input  logic       a_msb,
  input  logic       b_msb,
  input  logic       out_msb,
  output logic       ovf
);

  // Same-sign add or opposite-sign subtract that flips the sign of operand 1
  always_comb begin
    ovf = 1'b0;
    case (opcode)
      OP_ADD:  ovf = (a_msb == b_msb) && (out_msb != a_msb);
      OP_SUB:  ovf = (a_msb != b_msb) && (out_msb != a_msb);
      default: ovf = 1'b0;
    endcase
  end

endmodule

// File: rtl/alu_op_sequencer.sv
// Clocked request/response front end for the combinational alu_simple.
// One operation is in flight at a time: operands are launched on accept,
// the ALU result is captured SETTLE_CYCLES edges later and held until the
// consumer takes it.
module alu_op_sequencer
  import alu_seq_pkg::*;
#(
  parameter int SETTLE_CYCLES = 1,
  parameter int CNT_W         = 16
)
(
  input  logic              clk,
  input  logic              rst,

  input  logic              req_valid,
  output logic              req_ready,
  input  logic [DATA_W-1:0] req_In1,
  input  logic [DATA_W-1:0] req_In2,
  input  logic [3:0]        req_opcode,
  input  logic [4:0]        req_SR_Bit,
  input  logic [2:0]        req_SR_Cont,
  input  logic [3:0]        req_tag,

  output logic [DATA_W-1:0] alu_In1,
  output logic [DATA_W-1:0] alu_In2,
  output logic [3:0]        alu_opcode,
  output logic [4:0]        alu_SR_Bit,
  output logic [2:0]        alu_SR_Cont,
  input  logic [DATA_W-1:0] alu_Out,

  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_Out,
  output logic              rsp_ovf,
  output logic [3:0]        rsp_tag,
  output logic [CNT_W-1:0]  ovf_count
);

  localparam int SC_W = 4;

  generate
    if (SETTLE_CYCLES < 1 || SETTLE_CYCLES > 15) begin : g_bad_settle
      $error("alu_op_sequencer: SETTLE_CYCLES must be in 1..15");
    end
  endgenerate

  seq_state_t      state;
  logic [SC_W-1:0] settle_cnt;
  logic [3:0]      tag_q;
  logic            ovf;

  // Overflow is judged on the launched operands and the settled ALU output
  alu_ovf_detect u_ovf_detect (
    .opcode  (alu_opcode),
    .a_msb   (alu_In1[DATA_W-1]),
    .b_msb   (alu_In2[DATA_W-1]),
    .out_msb (alu_Out[DATA_W-1]),
    .ovf     (ovf)
  );

  // Ready is gated by reset so nothing is offered while the block is held
  assign req_ready = (state == IDLE) && !rst;
  assign rsp_tag   = tag_q;

  // Sequencer FSM: launch on accept, count down the settle time, hold the response
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      settle_cnt  <= '0;
      tag_q       <= '0;
      alu_In1     <= '0;
      alu_In2     <= '0;
      alu_opcode  <= '0;
      alu_SR_Bit  <= '0;
      alu_SR_Cont <= '0;
      rsp_valid   <= 1'b0;
      rsp_Out     <= '0;
      rsp_ovf     <= 1'b0;
      ovf_count   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            alu_In1     <= req_In1;
            alu_In2     <= req_In2;
            alu_opcode  <= req_opcode;
            alu_SR_Bit  <= req_SR_Bit;
            alu_SR_Cont <= req_SR_Cont;
            tag_q       <= req_tag;
            settle_cnt  <= SC_W'(SETTLE_CYCLES);
            state       <= SETTLE;
          end
        end
        SETTLE: begin
          if (settle_cnt == SC_W'(1)) begin
            rsp_Out    <= alu_Out;
            rsp_ovf    <= ovf;
            rsp_valid  <= 1'b1;
            settle_cnt <= '0;
            state      <= RESP;
            if (ovf && (ovf_count != {CNT_W{1'b1}})) begin
              ovf_count <= ovf_count + CNT_W'(1);
            end
          end else begin
            settle_cnt <= settle_cnt - SC_W'(1);
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Self-checking bench for alu_op_sequencer. Two instances share a clock:
// dut_a uses SETTLE_CYCLES=1 with a 16-bit counter, dut_b uses
// SETTLE_CYCLES=4 with a 2-bit counter. Each drives a small ALU model.
module tb_alu_op_sequencer;

  localparam int SETTLE_A = 1;
  localparam int SETTLE_B = 4;
  localparam logic [3:0] OPC_ADD = 4'b0000;
  localparam logic [3:0] OPC_SUB = 4'b0001;

  typedef struct {
    logic [31:0] out;
    logic        ovf;
    logic [3:0]  tag;
  } exp_t;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int exp_cnt_a = 0;

  exp_t sb_a[$];
  exp_t sb_b[$];

  logic clk = 1'b0;
  logic rst_a, rst_b;

  logic        req_valid_a, req_ready_a;
  logic [31:0] req_in1_a, req_in2_a;
  logic [3:0]  req_opcode_a, req_tag_a;
  logic [4:0]  req_sr_bit_a;
  logic [2:0]  req_sr_cont_a;
  logic [31:0] alu_in1_a, alu_in2_a, alu_out_a;
  logic [3:0]  alu_opcode_a;
  logic [4:0]  alu_sr_bit_a;
  logic [2:0]  alu_sr_cont_a;
  logic        rsp_valid_a, rsp_ready_a, rsp_ovf_a;
  logic [31:0] rsp_out_a;
  logic [3:0]  rsp_tag_a;
  logic [15:0] ovf_count_a;

  logic        req_valid_b, req_ready_b;
  logic [31:0] req_in1_b, req_in2_b;
  logic [3:0]  req_opcode_b, req_tag_b;
  logic [4:0]  req_sr_bit_b;
  logic [2:0]  req_sr_cont_b;
  logic [31:0] alu_in1_b, alu_in2_b, alu_out_b;
  logic [3:0]  alu_opcode_b;
  logic [4:0]  alu_sr_bit_b;
  logic [2:0]  alu_sr_cont_b;
  logic        rsp_valid_b, rsp_ready_b, rsp_ovf_b;
  logic [31:0] rsp_out_b;
  logic [3:0]  rsp_tag_b;
  logic [1:0]  ovf_count_b;

  // Stand-in for alu_simple: a few arithmetic, logic and shift operations
  function automatic logic [31:0] alu_model(input logic [31:0] a, input logic [31:0] b,
                                            input logic [3:0] op, input logic [4:0] sh,
                                            input logic [2:0] sc);
    case (op)
      4'd0:    return a + b;
      4'd1:    return a - b;
      4'd2:    return a & b;
      4'd3:    return a | b;
      4'd4:    return a ^ b;
      4'd5:    return sc[0] ? (a >> sh) : (a << sh);
      default: return b;
    endcase
  endfunction

  // Signed overflow expectation written from the operand/result signs
  function automatic logic exp_ovf(input logic [3:0] op, input logic [31:0] a,
                                   input logic [31:0] b, input logic [31:0] o);
    if (op == OPC_ADD) return (a[31] == b[31]) && (o[31] != a[31]);
    if (op == OPC_SUB) return (a[31] != b[31]) && (o[31] != a[31]);
    return 1'b0;
  endfunction

  assign alu_out_a = alu_model(alu_in1_a, alu_in2_a, alu_opcode_a, alu_sr_bit_a, alu_sr_cont_a);
  assign alu_out_b = alu_model(alu_in1_b, alu_in2_b, alu_opcode_b, alu_sr_bit_b, alu_sr_cont_b);

  alu_op_sequencer #(.SETTLE_CYCLES(SETTLE_A), .CNT_W(16)) dut_a (
    .clk(clk), .rst(rst_a),
    .req_valid(req_valid_a), .req_ready(req_ready_a),
    .req_In1(req_in1_a), .req_In2(req_in2_a), .req_opcode(req_opcode_a),
    .req_SR_Bit(req_sr_bit_a), .req_SR_Cont(req_sr_cont_a), .req_tag(req_tag_a),
    .alu_In1(alu_in1_a), .alu_In2(alu_in2_a), .alu_opcode(alu_opcode_a),
    .alu_SR_Bit(alu_sr_bit_a), .alu_SR_Cont(alu_sr_cont_a), .alu_Out(alu_out_a),
    .rsp_valid(rsp_valid_a), .rsp_ready(rsp_ready_a), .rsp_Out(rsp_out_a),
    .rsp_ovf(rsp_ovf_a), .rsp_tag(rsp_tag_a), .ovf_count(ovf_count_a)
  );

  alu_op_sequencer #(.SETTLE_CYCLES(SETTLE_B), .CNT_W(2)) dut_b (
    .clk(clk), .rst(rst_b),
    .req_valid(req_valid_b), .req_ready(req_ready_b),
    .req_In1(req_in1_b), .req_In2(req_in2_b), .req_opcode(req_opcode_b),
    .req_SR_Bit(req_sr_bit_b), .req_SR_Cont(req_sr_cont_b), .req_tag(req_tag_b),
    .alu_In1(alu_in1_b), .alu_In2(alu_in2_b), .alu_opcode(alu_opcode_b),
    .alu_SR_Bit(alu_sr_bit_b), .alu_SR_Cont(alu_sr_cont_b), .alu_Out(alu_out_b),
    .rsp_valid(rsp_valid_b), .rsp_ready(rsp_ready_b), .rsp_Out(rsp_out_b),
    .rsp_ovf(rsp_ovf_b), .rsp_tag(rsp_tag_b), .ovf_count(ovf_count_b)
  );

  // Free-running 100 MHz clock
  always #5 clk = ~clk;

  // Edge counter used to measure request spacing
  always @(posedge clk) cyc <= cyc + 1;

  // Hard stop in case a test wedges
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached, got no finish, want finish");
    $fatal(1, "[TB] watchdog");
  end

  // Offer one request to dut_a at a negedge; returns at the negedge after acceptance
  task automatic send_a(input logic [31:0] a, input logic [31:0] b, input logic [3:0] op,
                        input logic [4:0] sh, input logic [2:0] sc, input logic [3:0] tag,
                        output bit ok);
    exp_t e;
    req_in1_a = a; req_in2_a = b; req_opcode_a = op;
    req_sr_bit_a = sh; req_sr_cont_a = sc; req_tag_a = tag;
    req_valid_a = 1'b1;
    ok = 1'b0;
    for (int w = 0; w < 64 && !ok; w++) begin
      if (req_ready_a) begin @(posedge clk); ok = 1'b1; end
      else @(negedge clk);
    end
    if (ok) begin
      e.out = alu_model(a, b, op, sh, sc);
      e.ovf = exp_ovf(op, a, b, e.out);
      e.tag = tag;
      sb_a.push_back(e);
    end
    @(negedge clk);
    req_valid_a = 1'b0;
  endtask

  task automatic send_b(input logic [31:0] a, input logic [31:0] b, input logic [3:0] op,
                        input logic [4:0] sh, input logic [2:0] sc, input logic [3:0] tag,
                        output bit ok);
    exp_t e;
    req_in1_b = a; req_in2_b = b; req_opcode_b = op;
    req_sr_bit_b = sh; req_sr_cont_b = sc; req_tag_b = tag;
    req_valid_b = 1'b1;
    ok = 1'b0;
    for (int w = 0; w < 64 && !ok; w++) begin
      if (req_ready_b) begin @(posedge clk); ok = 1'b1; end
      else @(negedge clk);
    end
    if (ok) begin
      e.out = alu_model(a, b, op, sh, sc);
      e.ovf = exp_ovf(op, a, b, e.out);
      e.tag = tag;
      sb_b.push_back(e);
    end
    @(negedge clk);
    req_valid_b = 1'b0;
  endtask

  // Negedges waited until rsp_valid, or -1 if it never came
  task automatic wait_rsp_a(output int n);
    n = 0;
    while (!rsp_valid_a && n < 64) begin @(negedge clk); n++; end
    if (!rsp_valid_a) n = -1;
  endtask

  task automatic wait_rsp_b(output int n);
    n = 0;
    while (!rsp_valid_b && n < 64) begin @(negedge clk); n++; end
    if (!rsp_valid_b) n = -1;
  endtask

  // Outputs while reset is held and just after release
  task automatic test_reset();
    rst_a = 1'b1; rst_b = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (req_ready_a !== 1'b0) begin errors++; $display("[TB] FAIL reset_req_ready got %b want 0", req_ready_a); end
    checks++; if (rsp_valid_a !== 1'b0) begin errors++; $display("[TB] FAIL reset_rsp_valid got %b want 0", rsp_valid_a); end
    checks++; if ({alu_in1_a, alu_in2_a, alu_opcode_a, alu_sr_bit_a, alu_sr_cont_a} !== '0) begin
      errors++; $display("[TB] FAIL reset_alu got %h/%h/%h want all zero", alu_in1_a, alu_in2_a, alu_opcode_a); end
    checks++; if ({rsp_out_a, rsp_tag_a, rsp_ovf_a, ovf_count_a} !== '0) begin
      errors++; $display("[TB] FAIL reset_rsp got out=%h tag=%h ovf=%b cnt=%0d want zeros", rsp_out_a, rsp_tag_a, rsp_ovf_a, ovf_count_a); end
    rst_a = 1'b0; rst_b = 1'b0;
    @(negedge clk);
    checks++; if (req_ready_a !== 1'b1) begin errors++; $display("[TB] FAIL post_reset_ready got %b want 1", req_ready_a); end
    checks++; if (req_ready_b !== 1'b1) begin errors++; $display("[TB] FAIL post_reset_ready_b got %b want 1", req_ready_b); end
  endtask

  // Single operations: ADD overflow, ADD clean, SUB overflow, XOR with ADD-like signs
  task automatic test_single_ops();
    logic [31:0] va[4] = '{32'h80000001, 32'd5, 32'h80000000, 32'h80000000};
    logic [31:0] vb[4] = '{32'h80000001, 32'd7, 32'd1,         32'h80000000};
    logic [3:0]  vo[4] = '{OPC_ADD,      OPC_ADD, OPC_SUB,     4'd4};
    logic [3:0]  vt[4] = '{4'd3,         4'd9,    4'd12,       4'd6};
    logic [31:0] vx[4] = '{32'h00000002, 32'd12,  32'h7FFFFFFF, 32'h00000000};
    logic        vf[4] = '{1'b1,         1'b0,    1'b1,         1'b0};
    bit ok; int n; exp_t e;
    rsp_ready_a = 1'b1;
    for (int i = 0; i < 4; i++) begin
      send_a(va[i], vb[i], vo[i], 5'(i + 1), 3'(i), vt[i], ok);
      checks++; if (!ok) begin errors++; $display("[TB] FAIL single_accept[%0d] got no accept want accept", i); end
      checks++; if ({alu_in1_a, alu_in2_a, alu_opcode_a, alu_sr_bit_a, alu_sr_cont_a} !== {va[i], vb[i], vo[i], 5'(i + 1), 3'(i)}) begin
        errors++; $display("[TB] FAIL single_alu_launch[%0d] got %h %h %h %h %h", i, alu_in1_a, alu_in2_a, alu_opcode_a, alu_sr_bit_a, alu_sr_cont_a); end
      wait_rsp_a(n);
      checks++; if (n != SETTLE_A) begin errors++; $display("[TB] FAIL single_latency[%0d] got %0d want %0d", i, n, SETTLE_A); end
      if (n >= 0 && sb_a.size() > 0) begin
        e = sb_a.pop_front();
        if (e.ovf) exp_cnt_a++;
        checks++; if (rsp_out_a !== e.out || rsp_out_a !== vx[i]) begin errors++; $display("[TB] FAIL single_out[%0d] got %h want %h", i, rsp_out_a, vx[i]); end
        checks++; if (rsp_ovf_a !== e.ovf || rsp_ovf_a !== vf[i]) begin errors++; $display("[TB] FAIL single_ovf[%0d] got %b want %b", i, rsp_ovf_a, vf[i]); end
        checks++; if (rsp_tag_a !== e.tag) begin errors++; $display("[TB] FAIL single_tag[%0d] got %h want %h", i, rsp_tag_a, e.tag); end
        checks++; if (ovf_count_a !== 16'(exp_cnt_a)) begin errors++; $display("[TB] FAIL single_count[%0d] got %0d want %0d", i, ovf_count_a, exp_cnt_a); end
      end
      @(negedge clk);
    end
  endtask

  // Consumer stalls for 5 cycles while a new request waits
  task automatic test_backpressure();
    bit ok; int n; exp_t e;
    rsp_ready_a = 1'b0;
    send_a(32'h12345678, 32'h0F0F0F0F, 4'd3, 5'd0, 3'd0, 4'd5, ok);
    checks++; if (!ok) begin errors++; $display("[TB] FAIL bp_accept got no accept want accept"); end
    wait_rsp_a(n);
    checks++; if (n != SETTLE_A) begin errors++; $display("[TB] FAIL bp_latency got %0d want %0d", n, SETTLE_A); end
    req_in1_a = 32'hCAFEF00D; req_in2_a = 32'h00000011; req_opcode_a = OPC_SUB;
    req_sr_bit_a = 5'd0; req_sr_cont_a = 3'd0; req_tag_a = 4'd10; req_valid_a = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++; if (rsp_valid_a !== 1'b1 || rsp_out_a !== 32'h1F3F5F7F || rsp_tag_a !== 4'd5) begin
        errors++; $display("[TB] FAIL bp_hold[%0d] got v=%b out=%h tag=%h want v=1 out=1f3f5f7f tag=5", i, rsp_valid_a, rsp_out_a, rsp_tag_a); end
      checks++; if (req_ready_a !== 1'b0 || alu_in1_a !== 32'h12345678 || alu_opcode_a !== 4'd3) begin
        errors++; $display("[TB] FAIL bp_stall[%0d] got ready=%b in1=%h op=%h want 0/12345678/3", i, req_ready_a, alu_in1_a, alu_opcode_a); end
    end
    if (sb_a.size() > 0) begin
      e = sb_a.pop_front();
      if (e.ovf) exp_cnt_a++;
      checks++; if (rsp_out_a !== e.out || rsp_ovf_a !== e.ovf) begin errors++; $display("[TB] FAIL bp_result got %h/%b want %h/%b", rsp_out_a, rsp_ovf_a, e.out, e.ovf); end
    end
    rsp_ready_a = 1'b1;
    @(negedge clk);
    checks++; if (rsp_valid_a !== 1'b0 || req_ready_a !== 1'b1 || alu_in1_a !== 32'h12345678) begin
      errors++; $display("[TB] FAIL bp_release got v=%b ready=%b in1=%h want 0/1/12345678", rsp_valid_a, req_ready_a, alu_in1_a); end
    @(posedge clk);
    e.out = 32'hCAFEF00D - 32'h00000011; e.ovf = 1'b0; e.tag = 4'd10;
    sb_a.push_back(e);
    @(negedge clk);
    req_valid_a = 1'b0;
    checks++; if (alu_in1_a !== 32'hCAFEF00D || alu_opcode_a !== OPC_SUB) begin
      errors++; $display("[TB] FAIL bp_second_launch got %h/%h want cafef00d/1", alu_in1_a, alu_opcode_a); end
    wait_rsp_a(n);
    if (n >= 0 && sb_a.size() > 0) begin
      e = sb_a.pop_front();
      checks++; if (rsp_out_a !== e.out || rsp_tag_a !== e.tag || rsp_ovf_a !== e.ovf) begin
        errors++; $display("[TB] FAIL bp_second got %h/%h/%b want %h/%h/%b", rsp_out_a, rsp_tag_a, rsp_ovf_a, e.out, e.tag, e.ovf); end
    end else begin
      checks++; errors++; $display("[TB] FAIL bp_second got no response want response");
    end
    @(negedge clk);
  endtask

  // Requests held continuously valid: random ops, spacing of SETTLE+2 edges
  task automatic test_back_to_back();
    rsp_ready_a = 1'b1;
    fork
      begin
        int acc_prev; bit got; exp_t e;
        logic [31:0] a, b; logic [3:0] op; logic [4:0] sh; logic [2:0] sc;
        acc_prev = -1;
        for (int i = 0; i < 8; i++) begin
          a = (i % 3 == 0) ? 32'h7FFFFFF0 : $urandom;
          b = (i % 3 == 0) ? 32'h00000100 : $urandom;
          op = (i % 3 == 0) ? OPC_ADD : 4'($urandom_range(0, 5));
          sh = 5'($urandom_range(0, 31)); sc = 3'($urandom_range(0, 7));
          req_in1_a = a; req_in2_a = b; req_opcode_a = op;
          req_sr_bit_a = sh; req_sr_cont_a = sc; req_tag_a = 4'(i); req_valid_a = 1'b1;
          got = 1'b0;
          for (int w = 0; w < 64 && !got; w++) begin
            if (req_ready_a) begin @(posedge clk); got = 1'b1; end
            else @(negedge clk);
          end
          if (got) begin
            e.out = alu_model(a, b, op, sh, sc); e.ovf = exp_ovf(op, a, b, e.out); e.tag = 4'(i);
            sb_a.push_back(e);
          end else begin
            checks++; errors++; $display("[TB] FAIL b2b_accept[%0d] got no accept want accept", i);
          end
          @(negedge clk);
          if (got && acc_prev >= 0) begin
            checks++; if (cyc - acc_prev != SETTLE_A + 2) begin errors++; $display("[TB] FAIL b2b_spacing[%0d] got %0d want %0d", i, cyc - acc_prev, SETTLE_A + 2); end
          end
          acc_prev = cyc;
        end
        req_valid_a = 1'b0;
      end
      begin
        int n; exp_t r;
        for (int k = 0; k < 8; k++) begin
          wait_rsp_a(n);
          if (n < 0 || sb_a.size() == 0) begin
            checks++; errors++; $display("[TB] FAIL b2b_rsp[%0d] got no response want response", k);
          end else begin
            r = sb_a.pop_front();
            if (r.ovf) exp_cnt_a++;
            checks++; if (rsp_out_a !== r.out || rsp_ovf_a !== r.ovf || rsp_tag_a !== r.tag) begin
              errors++; $display("[TB] FAIL b2b_rsp[%0d] got %h/%b/%h want %h/%b/%h", k, rsp_out_a, rsp_ovf_a, rsp_tag_a, r.out, r.ovf, r.tag); end
            checks++; if (ovf_count_a !== 16'(exp_cnt_a)) begin errors++; $display("[TB] FAIL b2b_count[%0d] got %0d want %0d", k, ovf_count_a, exp_cnt_a); end
          end
          @(negedge clk);
        end
      end
    join
  endtask

  // Asynchronous reset during SETTLE and during RESP on the slow instance
  task automatic test_reset_mid_op();
    bit ok; int n;
    rsp_ready_b = 1'b1;
    send_b(32'h80000001, 32'h80000001, OPC_ADD, 5'd3, 3'd5, 4'd7, ok);
    checks++; if (!ok) begin errors++; $display("[TB] FAIL rmid_accept got no accept want accept"); end
    @(posedge clk); @(posedge clk);
    #2 rst_b = 1'b1;
    #1;
    checks++; if (rsp_valid_b !== 1'b0 || req_ready_b !== 1'b0) begin errors++; $display("[TB] FAIL rmid_settle got v=%b ready=%b want 0/0", rsp_valid_b, req_ready_b); end
    checks++; if ({alu_in1_b, alu_in2_b, alu_opcode_b, alu_sr_bit_b, alu_sr_cont_b} !== '0) begin
      errors++; $display("[TB] FAIL rmid_alu got %h/%h/%h/%h/%h want zeros", alu_in1_b, alu_in2_b, alu_opcode_b, alu_sr_bit_b, alu_sr_cont_b); end
    sb_b.delete();
    @(negedge clk);
    rst_b = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      checks++; if (rsp_valid_b !== 1'b0 || req_ready_b !== 1'b1) begin
        errors++; $display("[TB] FAIL rmid_no_stale[%0d] got v=%b ready=%b want 0/1", i, rsp_valid_b, req_ready_b); end
    end
    rsp_ready_b = 1'b0;
    send_b(32'd1, 32'd2, OPC_ADD, 5'd0, 3'd0, 4'd8, ok);
    wait_rsp_b(n);
    checks++; if (n != SETTLE_B) begin errors++; $display("[TB] FAIL rmid_resp_latency got %0d want %0d", n, SETTLE_B); end
    #2 rst_b = 1'b1;
    #1;
    checks++; if (rsp_valid_b !== 1'b0 || rsp_out_b !== 32'd0 || rsp_tag_b !== 4'd0) begin
      errors++; $display("[TB] FAIL rmid_resp_drop got v=%b out=%h tag=%h want 0/0/0", rsp_valid_b, rsp_out_b, rsp_tag_b); end
    sb_b.delete();
    @(negedge clk);
    rst_b = 1'b0;
    rsp_ready_b = 1'b1;
    @(negedge clk);
    checks++; if (ovf_count_b !== 2'd0 || req_ready_b !== 1'b1) begin errors++; $display("[TB] FAIL rmid_after got cnt=%0d ready=%b want 0/1", ovf_count_b, req_ready_b); end
  endtask

  // Five overflowing ADDs into a 2-bit counter
  task automatic test_saturation();
    int sat_exp[5] = '{1, 2, 3, 3, 3};
    bit ok; int n; exp_t e;
    rsp_ready_b = 1'b1;
    for (int i = 0; i < 5; i++) begin
      send_b(32'h7FFFFFFF, 32'(i + 1), OPC_ADD, 5'd0, 3'd0, 4'(i + 1), ok);
      checks++; if (!ok) begin errors++; $display("[TB] FAIL sat_accept[%0d] got no accept want accept", i); end
      wait_rsp_b(n);
      checks++; if (n != SETTLE_B) begin errors++; $display("[TB] FAIL sat_latency[%0d] got %0d want %0d", i, n, SETTLE_B); end
      if (n >= 0 && sb_b.size() > 0) begin
        e = sb_b.pop_front();
        checks++; if (rsp_out_b !== e.out || rsp_ovf_b !== e.ovf || rsp_tag_b !== e.tag) begin
          errors++; $display("[TB] FAIL sat_rsp[%0d] got %h/%b/%h want %h/%b/%h", i, rsp_out_b, rsp_ovf_b, rsp_tag_b, e.out, e.ovf, e.tag); end
        checks++; if (ovf_count_b !== 2'(sat_exp[i])) begin errors++; $display("[TB] FAIL sat_count[%0d] got %0d want %0d", i, ovf_count_b, sat_exp[i]); end
      end
      @(negedge clk);
    end
  endtask

  // Test sequence
  initial begin
    rst_a = 1'b1; rst_b = 1'b1;
    req_valid_a = 1'b0; req_in1_a = '0; req_in2_a = '0; req_opcode_a = '0;
    req_sr_bit_a = '0; req_sr_cont_a = '0; req_tag_a = '0; rsp_ready_a = 1'b0;
    req_valid_b = 1'b0; req_in1_b = '0; req_in2_b = '0; req_opcode_b = '0;
    req_sr_bit_b = '0; req_sr_cont_b = '0; req_tag_b = '0; rsp_ready_b = 1'b0;
    test_reset();
    test_single_ops();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_op();
    test_saturation();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
